// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Next-address controller for the program counter register. Each cycle it
// decodes the flow-control class of the current instruction and drives the
// PC register's `target` input. It handles sequential fetch, conditional
// relative branches, absolute jumps, call/return through a small
// return-address stack, stall and halt. It also owns the core's run/halt
// state.
//
// Interface timing: there is no handshake. `target` is a purely
// combinational function of the current state and inputs, and it is valid
// in every cycle. The PC register captures it on the next rising clk edge,
// so a redirect takes effect one cycle after its `op` is presented.
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      pulse: begin/restart execution at address 0
//   stall      in   1      hold the current PC
//   prog_ctr   in   D      current PC register value
//   op         in   3      flow class (SEQ/BR/JMP/CALL/RET/HALT, 11x = SEQ)
//   cond_flag  in   1      branch condition
//   rel_off    in   OFF_W  signed two's-complement branch offset
//   abs_addr   in   D      absolute jump/call address
//   target     out  D      next PC value (combinational)
//   running    out  1      registered, high in RUN
//   done       out  1      registered, high in HALTED
//   stack_err  out  1      registered, sticky stack overflow/underflow
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int D     = 12,
    parameter int OFF_W = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic [D-1:0]     prog_ctr,
    input  logic [2:0]       op,
    input  logic             cond_flag,
    input  logic [OFF_W-1:0] rel_off,
    input  logic [D-1:0]     abs_addr,
    output logic [D-1:0]     target,
    output logic             running,
    output logic             done,
    output logic             stack_err
);

    // sp counts valid entries 0..DEPTH, so it needs one bit more than the
    // stack index.
    localparam int IDX_W = $clog2(DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BR   = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [D-1:0]    stack_mem [DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_next;
    logic [SP_W-1:0] sp_dec;

    logic            push_en;
    logic [D-1:0]    push_data;
    logic            err_set;
    logic            err_clr;

    logic [D-1:0]    pc_inc;
    logic [D-1:0]    off_ext;
    logic [D-1:0]    br_taken;
    logic            stack_full;
    logic            stack_empty;
    logic [D-1:0]    stack_top;

    // -----------------------------------------------------------------------
    // Address arithmetic. All sums wrap modulo 2^D by truncation.
    // -----------------------------------------------------------------------
    assign pc_inc   = prog_ctr + {{(D-1){1'b0}}, 1'b1};
    assign off_ext  = {{(D-OFF_W){rel_off[OFF_W-1]}}, rel_off};
    assign br_taken = prog_ctr + off_ext;

    // -----------------------------------------------------------------------
    // Stack status. The top entry lives at index sp-1. The push slot is
    // index sp, and that slot only exists while sp < DEPTH, so its MSB is 0.
    // -----------------------------------------------------------------------
    assign stack_full  = (sp == SP_W'(DEPTH));
    assign stack_empty = (sp == '0);
    assign sp_dec      = sp - SP_W'(1);
    assign stack_top   = stack_mem[sp_dec[IDX_W-1:0]];

    // -----------------------------------------------------------------------
    // Next-state / next-address decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state;
        target     = '0;
        sp_next    = sp;
        push_en    = 1'b0;
        push_data  = pc_inc;
        err_set    = 1'b0;
        err_clr    = 1'b0;

        case (state)
            IDLE: begin
                target = '0;
                if (start) begin
                    state_next = RUN;
                    sp_next    = '0;
                    err_clr    = 1'b1;
                end
            end

            RUN: begin
                if (start) begin
                    // A restart overrides both stall and op.
                    target  = '0;
                    sp_next = '0;
                    err_clr = 1'b1;
                end else if (stall) begin
                    target = prog_ctr;
                end else begin
                    case (op)
                        OP_SEQ: target = pc_inc;
                        OP_BR:  target = cond_flag ? br_taken : pc_inc;
                        OP_JMP: target = abs_addr;
                        OP_CALL: begin
                            // The jump is always taken. On overflow only the
                            // return address is lost.
                            target = abs_addr;
                            if (stack_full) begin
                                err_set = 1'b1;
                            end else begin
                                push_en = 1'b1;
                                sp_next = sp + SP_W'(1);
                            end
                        end
                        OP_RET: begin
                            // On underflow, fall through to the next
                            // instruction.
                            if (stack_empty) begin
                                target  = pc_inc;
                                err_set = 1'b1;
                            end else begin
                                target  = stack_top;
                                sp_next = sp_dec;
                            end
                        end
                        OP_HALT: begin
                            target     = prog_ctr;
                            state_next = HALTED;
                        end
                        default: target = pc_inc;
                    endcase
                end
            end

            HALTED: begin
                target = prog_ctr;
                if (start) begin
                    target     = '0;
                    state_next = RUN;
                    sp_next    = '0;
                    err_clr    = 1'b1;
                end
            end

            default: begin
                target     = '0;
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, stack and flag registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sp        <= '0;
            stack_err <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            state <= state_next;
            sp    <= sp_next;
            // running/done follow the state being entered, so they change on
            // the same edge as the transition.
            running <= (state_next == RUN);
            done    <= (state_next == HALTED);
            if (err_clr) begin
                stack_err <= 1'b0;
            end else if (err_set) begin
                stack_err <= 1'b1;
            end
            if (push_en) begin
                stack_mem[sp[IDX_W-1:0]] <= push_data;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. Inputs are driven one cycle at a time.
// The expected {target, running, done, stack_err} for each cycle is pushed
// into a queue. A monitor on the falling edge pops one entry and compares
// it against the DUT.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam int D     = 12;
    localparam int OFF_W = 8;
    localparam int DEPTH = 4;
    localparam int EW    = D + 3;

    localparam logic [2:0] SEQ  = 3'b000;
    localparam logic [2:0] BR   = 3'b001;
    localparam logic [2:0] JMP  = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;
    localparam logic [2:0] HALT = 3'b101;
    localparam logic [2:0] RSV  = 3'b110;

    logic             clk;
    logic             reset;
    logic             start;
    logic             stall;
    logic [D-1:0]     prog_ctr;
    logic [2:0]       op;
    logic             cond_flag;
    logic [OFF_W-1:0] rel_off;
    logic [D-1:0]     abs_addr;
    logic [D-1:0]     target;
    logic             running;
    logic             done;
    logic             stack_err;

    logic [EW-1:0] exp_q[$];
    int            id_q[$];
    int            checks;
    int            errors;
    int            step;

    pc_sequencer #(.D(D), .OFF_W(OFF_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stall     (stall),
        .prog_ctr  (prog_ctr),
        .op        (op),
        .cond_flag (cond_flag),
        .rel_off   (rel_off),
        .abs_addr  (abs_addr),
        .target    (target),
        .running   (running),
        .done      (done),
        .stack_err (stack_err)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver ----------------
    task automatic drive(input logic s, input logic st, input logic [D-1:0] pc,
                         input logic [2:0] o, input logic c,
                         input logic [OFF_W-1:0] off, input logic [D-1:0] abs_a);
        start     = s;
        stall     = st;
        prog_ctr  = pc;
        op        = o;
        cond_flag = c;
        rel_off   = off;
        abs_addr  = abs_a;
    endtask

    task automatic expect_now(input logic [D-1:0] t, input logic r,
                              input logic d, input logic e);
        step++;
        exp_q.push_back({t, r, d, e});
        id_q.push_back(step);
    endtask

    // One cycle: apply inputs just after the edge and queue the expected
    // response for that cycle.
    task automatic cyc(input logic s, input logic st, input logic [D-1:0] pc,
                       input logic [2:0] o, input logic c,
                       input logic [OFF_W-1:0] off, input logic [D-1:0] abs_a,
                       input logic [D-1:0] t, input logic r, input logic d,
                       input logic e);
        @(posedge clk);
        #1;
        drive(s, st, pc, o, c, off, abs_a);
        expect_now(t, r, d, e);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] exp_v;
            logic [EW-1:0] act_v;
            int            id;
            exp_v = exp_q.pop_front();
            id    = id_q.pop_front();
            act_v = {target, running, done, stack_err};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL step%0d: got target=%h run=%b done=%b err=%b, want target=%h run=%b done=%b err=%b",
                         id, act_v[EW-1:3], act_v[2], act_v[1], act_v[0],
                         exp_v[EW-1:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        step   = 0;
        reset  = 1'b1;
        drive(1'b0, 1'b0, 12'h000, SEQ, 1'b0, 8'h00, 12'h000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        //   start stall pc       op    c     off    abs      target   r d e
        // IDLE ignores op and stall
        cyc(1'b0, 1'b1, 12'h123, JMP,  1'b0, 8'h00, 12'h555, 12'h000, 0,0,0);
        cyc(1'b1, 1'b0, 12'h123, JMP,  1'b0, 8'h00, 12'h555, 12'h000, 0,0,0);
        // sequential fetch 0..5
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, D'(i), SEQ, 1'b0, 8'h00, 12'h000, D'(i + 1), 1,0,0);
        end
        // branches
        cyc(1'b0, 1'b0, 12'h010, BR,   1'b1, 8'hFC, 12'h000, 12'h00C, 1,0,0);
        cyc(1'b0, 1'b0, 12'h00C, BR,   1'b0, 8'hFC, 12'h000, 12'h00D, 1,0,0);
        cyc(1'b0, 1'b0, 12'h002, BR,   1'b1, 8'hFC, 12'h000, 12'hFFE, 1,0,0);
        cyc(1'b0, 1'b0, 12'h010, BR,   1'b1, 8'h7F, 12'h000, 12'h08F, 1,0,0);
        cyc(1'b0, 1'b0, 12'h010, JMP,  1'b0, 8'h00, 12'hABC, 12'hABC, 1,0,0);
        // call / return
        cyc(1'b0, 1'b0, 12'h020, CALL, 1'b0, 8'h00, 12'h100, 12'h100, 1,0,0);
        cyc(1'b0, 1'b0, 12'h105, CALL, 1'b0, 8'h00, 12'h200, 12'h200, 1,0,0);
        cyc(1'b0, 1'b0, 12'h200, RET,  1'b0, 8'h00, 12'h000, 12'h106, 1,0,0);
        cyc(1'b0, 1'b0, 12'h106, RET,  1'b0, 8'h00, 12'h000, 12'h021, 1,0,0);
        cyc(1'b0, 1'b0, 12'h021, RSV,  1'b0, 8'h00, 12'h777, 12'h022, 1,0,0);
        // overflow: 5 nested calls, the 5th return address is lost
        cyc(1'b0, 1'b0, 12'h300, CALL, 1'b0, 8'h00, 12'h400, 12'h400, 1,0,0);
        cyc(1'b0, 1'b0, 12'h310, CALL, 1'b0, 8'h00, 12'h400, 12'h400, 1,0,0);
        cyc(1'b0, 1'b0, 12'h320, CALL, 1'b0, 8'h00, 12'h400, 12'h400, 1,0,0);
        cyc(1'b0, 1'b0, 12'h330, CALL, 1'b0, 8'h00, 12'h400, 12'h400, 1,0,0);
        cyc(1'b0, 1'b0, 12'h340, CALL, 1'b0, 8'h00, 12'h400, 12'h400, 1,0,0);
        cyc(1'b0, 1'b0, 12'h400, RET,  1'b0, 8'h00, 12'h000, 12'h331, 1,0,1);
        cyc(1'b0, 1'b0, 12'h400, RET,  1'b0, 8'h00, 12'h000, 12'h321, 1,0,1);
        cyc(1'b0, 1'b0, 12'h400, RET,  1'b0, 8'h00, 12'h000, 12'h311, 1,0,1);
        cyc(1'b0, 1'b0, 12'h400, RET,  1'b0, 8'h00, 12'h000, 12'h301, 1,0,1);
        cyc(1'b0, 1'b0, 12'h400, RET,  1'b0, 8'h00, 12'h000, 12'h401, 1,0,1);
        cyc(1'b1, 1'b0, 12'h400, RET,  1'b0, 8'h00, 12'h000, 12'h000, 1,0,1);
        cyc(1'b0, 1'b0, 12'h000, SEQ,  1'b0, 8'h00, 12'h000, 12'h001, 1,0,0);
        // wrap, then stall blocks jump and call
        cyc(1'b0, 1'b0, 12'hFFF, SEQ,  1'b0, 8'h00, 12'h000, 12'h000, 1,0,0);
        cyc(1'b0, 1'b1, 12'h000, JMP,  1'b0, 8'h00, 12'h500, 12'h000, 1,0,0);
        cyc(1'b0, 1'b1, 12'h050, CALL, 1'b0, 8'h00, 12'h500, 12'h050, 1,0,0);
        // empty stack proves the stalled CALL did not push
        cyc(1'b0, 1'b0, 12'h000, RET,  1'b0, 8'h00, 12'h000, 12'h001, 1,0,0);
        // start wins over stall and clears the error
        cyc(1'b1, 1'b1, 12'h777, JMP,  1'b0, 8'h00, 12'h500, 12'h000, 1,0,1);
        cyc(1'b0, 1'b0, 12'h000, SEQ,  1'b0, 8'h00, 12'h000, 12'h001, 1,0,0);
        // halt
        cyc(1'b0, 1'b0, 12'h030, HALT, 1'b0, 8'h00, 12'h000, 12'h030, 1,0,0);
        cyc(1'b0, 1'b0, 12'h030, JMP,  1'b0, 8'h00, 12'h999, 12'h030, 0,1,0);
        cyc(1'b0, 1'b1, 12'h030, CALL, 1'b0, 8'h00, 12'h999, 12'h030, 0,1,0);
        cyc(1'b1, 1'b0, 12'h030, SEQ,  1'b0, 8'h00, 12'h000, 12'h000, 0,1,0);
        cyc(1'b0, 1'b0, 12'h000, SEQ,  1'b0, 8'h00, 12'h000, 12'h001, 1,0,0);
        // push something, then reset asynchronously mid-cycle
        cyc(1'b0, 1'b0, 12'h070, CALL, 1'b0, 8'h00, 12'h080, 12'h080, 1,0,0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 12'h060, SEQ, 1'b0, 8'h00, 12'h000);
        #1 reset = 1'b1;
        expect_now(12'h000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b0, 1'b0, 12'h060, SEQ, 1'b0, 8'h00, 12'h000);
        expect_now(12'h000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 12'h060, SEQ,  1'b0, 8'h00, 12'h000, 12'h000, 0,0,0);
        // reset emptied the stack, so this RET underflows
        cyc(1'b0, 1'b0, 12'h010, RET,  1'b0, 8'h00, 12'h000, 12'h011, 1,0,0);
        cyc(1'b0, 1'b0, 12'h011, SEQ,  1'b0, 8'h00, 12'h000, 12'h012, 1,0,1);

        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
